// File: rtl/cfg_lut_logic.sv
// Registered NUM_CH-channel lookup-table logic cell with a serially loadable table,
// rising-edge pulses and a saturating event counter on channel 0.
module cfg_lut_logic #(
   parameter int NUM_IN = 3,
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 8,
   parameter logic [NUM_CH*(2**NUM_IN)-1:0] DEFAULT_TBL = {8'h0F, 8'h8F}
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic [NUM_IN-1:0] in_vec,
   input  logic              cfg_start,
   input  logic              cfg_valid,
   input  logic              cfg_data,
   input  logic              cnt_clr,
   output logic [NUM_CH-1:0] out_vec,
   output logic [NUM_CH-1:0] out_rise,
   output logic [CNT_W-1:0]  evt_cnt,
   output logic              cfg_busy,
   output logic              cfg_done,
   output logic [1:0]        dbg_state
);

   localparam int DEPTH = 2**NUM_IN;
   localparam int TBL_W = NUM_CH * DEPTH;
   localparam int BC_W  = $clog2(TBL_W) + 1;

   // Handshake: cfg_valid qualifies cfg_data with no backpressure; every valid beat
   // seen in SHIFT is accepted, valid beats outside SHIFT are dropped.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [BC_W-1:0]     bitcnt_q, bitcnt_d;
   logic [TBL_W-1:0]    shadow_q, shadow_d;
   logic [TBL_W-1:0]    tbl_q, tbl_d;
   logic [NUM_IN-1:0]   in_q, in_d;
   logic [NUM_CH-1:0]   out_q, out_d;
   logic [NUM_CH-1:0]   rise_q, rise_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [NUM_CH-1:0]   lut_val;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      logic [DEPTH-1:0] ch_tbl;
      assign ch_tbl     = tbl_q[k*DEPTH +: DEPTH];
      assign lut_val[k] = ch_tbl[in_q];
   end

   always_comb begin
      in_d   = in_vec;
      out_d  = lut_val;
      rise_d = lut_val & ~out_q;
      cnt_d  = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (rise_q[0] && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      shadow_d = shadow_q;
      tbl_d    = tbl_q;
      case (state_q)
         IDLE: begin
            if (cfg_start) begin
               state_d  = SHIFT;
               bitcnt_d = '0;
            end
         end
         SHIFT: begin
            if (cfg_valid) begin
               shadow_d = {shadow_q[TBL_W-2:0], cfg_data};
               bitcnt_d = bitcnt_q + 1'b1;
               if (bitcnt_q == BC_W'(TBL_W - 1)) begin
                  state_d = COMMIT;
               end
            end
         end
         COMMIT: begin
            // Active table swaps here, so the datapath never sees a partial load.
            tbl_d   = shadow_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         bitcnt_q <= '0;
         shadow_q <= '0;
         tbl_q    <= DEFAULT_TBL;
         in_q     <= '0;
         out_q    <= '0;
         rise_q   <= '0;
         cnt_q    <= '0;
      end else if (ena) begin
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         shadow_q <= shadow_d;
         tbl_q    <= tbl_d;
         in_q     <= in_d;
         out_q    <= out_d;
         rise_q   <= rise_d;
         cnt_q    <= cnt_d;
      end
   end

   assign out_vec   = out_q;
   assign out_rise  = rise_q;
   assign evt_cnt   = cnt_q;
   assign cfg_busy  = (state_q == SHIFT);
   assign cfg_done  = (state_q == COMMIT);
   assign dbg_state = state_q;

endmodule
